// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// alu_op codes and datapath select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational state -> datapath strobe decode for the multi-cycle control FSM.
// With MEM_WAIT_EN defined, FETCH only commits PC/IR in the cycle memory is ready.
module multi_cycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op
);

    logic fetch_commit;

`ifdef MEM_WAIT_EN
    assign fetch_commit = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign fetch_commit     = 1'b1;
`endif

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_AND;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = fetch_commit;
                pc_write  = fetch_commit;
                alu_src_b = ALUB_FOUR;
                alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH2;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: reg_write  = 1'b1;
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Main sequencer of the multi-cycle MIPS core: state register and next-state logic.
// Optional MEM_WAIT_EN: FETCH/MEM_READ/MEM_WRITE hold until mem_ready.
module multi_cycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = S_ADDI_EXEC;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            // opcode is still held by the IR, so lw/sw split here
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ok ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ok ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_ILLEGAL:   state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    multi_cycle_ctrl_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op)
    );

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Scoreboard bench for multi_cycle_control_fsm: expected state/strobe vectors are
// queued per instruction and compared every cycle on the falling clock edge.
module tb_multi_cycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] outs;
    } exp_t;

    exp_t sb_q[$];

    wire [17:0] outs_w = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                          alu_op, illegal_op};

    multi_cycle_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference strobe vector per state, written straight from the state table.
    function automatic logic [17:0] exp_out(input logic [3:0] s);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00;
        pcs = 2'b00;
        aop = 3'b000;
        case (s)
            4'd1:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; aop = 3'b010; end
            4'd2:  begin asb = 2'b11; aop = 3'b010; end
            4'd3:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
            4'd4:  begin mr = 1; iod = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iod = 1; end
            4'd7:  begin asa = 1; aop = 3'b111; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin asa = 1; aop = 3'b110; pwc = 1; pcs = 2'b01; end
            4'd10: begin pw = 1; pcs = 2'b10; end
            4'd11: begin asa = 1; asb = 2'b10; aop = 3'b010; end
            4'd12: rw = 1;
            4'd13: ill = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill};
    endfunction

    task automatic push_state(input logic [3:0] s);
        exp_t e;
        e.st   = s;
        e.outs = exp_out(s);
        sb_q.push_back(e);
    endtask

    task automatic push_instr(input logic [5:0] op);
        push_state(4'd1);
        push_state(4'd2);
        case (op)
            6'b000000: begin push_state(4'd7); push_state(4'd8); end
            6'b100011: begin push_state(4'd3); push_state(4'd4); push_state(4'd5); end
            6'b101011: begin push_state(4'd3); push_state(4'd6); end
            6'b000100: push_state(4'd9);
            6'b000010: push_state(4'd10);
            6'b001000: begin push_state(4'd11); push_state(4'd12); end
            default:   push_state(4'd13);
        endcase
    endtask

    // Called on a falling edge just before FETCH is entered.
    task automatic run_instr(input string tag, input logic [5:0] op);
        exp_t e;
        int   n;
        opcode = op;
        push_instr(op);
        n = sb_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            chk({tag, "_state"}, {28'd0, state}, {28'd0, e.st});
            chk({tag, "_outs"}, {14'd0, outs_w}, {14'd0, e.outs});
        end
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        logic [5:0] rnd_op;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;

        repeat (3) begin
            @(negedge clk);
            chk("rst_state", {28'd0, state}, 32'd0);
            chk("rst_outs", {14'd0, outs_w}, 32'd0);
        end
        rst_n = 1'b1;

        run_instr("rtype", 6'b000000);
        run_instr("lw", 6'b100011);
        run_instr("sw", 6'b101011);
        run_instr("beq", 6'b000100);
        run_instr("j", 6'b000010);
        run_instr("illegal", 6'b111111);
        run_instr("addi", 6'b001000);
        run_instr("illegal2", 6'b100010);
        for (int k = 0; k < 6; k++) begin
            rnd_op = 6'($urandom_range(0, 63));
            run_instr("rand", rnd_op);
        end

        // Reset dropped between clock edges while in MEM_READ.
        opcode = 6'b100011;
        repeat (4) @(negedge clk);
        chk("mid_pre_state", {28'd0, state}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {28'd0, state}, 32'd0);
        chk("mid_rst_outs", {14'd0, outs_w}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", {28'd0, state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("after_rst", 6'b000000);

`ifdef MEM_WAIT_EN
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("wait_state", {28'd0, state}, 32'd1);
            chk("wait_pc_write", {31'd0, pc_write}, 32'd0);
            chk("wait_ir_write", {31'd0, ir_write}, 32'd0);
            chk("wait_mem_read", {31'd0, mem_read}, 32'd1);
        end
        mem_ready = 1'b1;
        #1;
        chk("ready_pc_write", {31'd0, pc_write}, 32'd1);
        chk("ready_ir_write", {31'd0, ir_write}, 32'd1);
        @(negedge clk);
        chk("ready_decode", {28'd0, state}, 32'd2);
        @(negedge clk);
        chk("ready_exec", {28'd0, state}, 32'd7);
        @(negedge clk);
        chk("ready_wb", {28'd0, state}, 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
